cond_logic: RTL and testbench
=============================

# cond_logic

Conditional-execution and flag-register stage that sits directly downstream of the ALU in the ARM processor datapath. It holds the architectural NZCV flags and updates them from the ALU's `ALUFlags` under S-bit control. It evaluates each instruction's 4-bit condition field against the stored flags and gates the decoder's PC/register/memory write-enables. It also returns the stored carry to the ALU for ADC.

## Interface
- `RESET_FLAGS`, default 4'b0000: NZCV value loaded on reset, ordered {N,Z,C,V}.
- `CLK` in 1: single clock; all state updates on the rising edge.
- `RESET` in 1: asynchronous, active-low reset.
- `Cond` in 4: instruction condition field, bits [31:28].
- `ALUFlags` in 4: {N,Z,C,V} from the ALU, same cycle.
- `FlagW` in 2: flag write request from the decoder; [1] writes N,Z; [0] writes C,V.
- `PCS` in 1: decoder PC-write request.
- `RegW` in 1: decoder register-write request.
- `MemW` in 1: decoder memory-write request.
- `NoWrite` in 1: compare-type instruction; suppresses the register write.
- `Stall` in 1: multi-cycle unit busy; freezes all architectural updates.
- `PCSrc` out 1: gated PC write.
- `RegWrite` out 1: gated register write.
- `MemWrite` out 1: gated memory write.
- `CondEx` out 1: the condition passed against the current stored flags.
- `C_Flag` out 1: stored C, fed to the ALU carry-in for ADC.
- `Flags` out 4: stored {N,Z,C,V}, for debug and trace.

## Operation
- **State:** two registered fields, NZ[1:0] and CV[1:0].
  - No other state.
- **Condition decode:** combinational, from the stored flags only (never from `ALUFlags`):
  - EQ 0000: Z. NE 0001: ~Z.
  - CS 0010: C. CC 0011: ~C.
  - MI 0100: N. PL 0101: ~N.
  - VS 0110: V. VC 0111: ~V.
  - HI 1000: C&~Z. LS 1001: ~C|Z.
  - GE 1010: N~^V. LT 1011: N^V.
  - GT 1100: ~Z&(N~^V). LE 1101: Z|(N^V).
  - AL 1110: 1.
  - 1111: treated as 1. Decoding of that encoding is the decoder's job.
- **Gating:**
  - PCSrc = PCS & CondEx & ~Stall.
  - RegWrite = RegW & ~NoWrite & CondEx & ~Stall.
  - MemWrite = MemW & CondEx & ~Stall.
- **Flag update:** at the rising edge, when CondEx & ~Stall:
  - if FlagW[1], NZ ← ALUFlags[3:2];
  - if FlagW[0], CV ← ALUFlags[1:0];
  - otherwise the field holds.
- **Failed condition:** an instruction whose condition fails updates nothing, including flags.
- **Stall behaviour:** while `Stall`=1, the flags hold regardless of FlagW, and all gated enables are 0. After Stall drops, the instruction still presented is evaluated normally in that cycle.
- **Outputs:** `C_Flag` = stored C; `Flags` = {NZ,CV}. Both change only after a clock edge or a reset.

## Timing
- Reset values, applied asynchronously while RESET=0:
  - `Flags` = RESET_FLAGS;
  - `C_Flag` = RESET_FLAGS[1];
  - `CondEx` and the gated enables follow combinationally from RESET_FLAGS and the current inputs.
- **Decode latency:** zero. `CondEx` and the gated enables are combinational in the same cycle as `Cond`.
- **Flag latency:** one edge. Flags written at edge k are visible to `Cond` from cycle k+1, so back-to-back CMP then BEQ works without forwarding.
- **Simultaneous read and write:** an S-suffixed conditional instruction evaluates on the old flags and writes new flags at the edge. No bypass is allowed.
- **ADC:** `C_Flag` is the pre-edge C, so ADCS uses the old C and writes the new C.
- **Reset mid-operation:** the flags reset immediately, independent of CLK. Release is synchronous to the first edge after RESET=1, and no update occurs on that edge unless the normal conditions hold.
- **Partial writes:** FlagW = 2'b01 or 2'b10 updates exactly one field. Each field has an independent enable.

## Structure
- Shared package holds:
  - the 4-bit condition-code constants (EQ…AL);
  - the flag bit indices (N=3, Z=2, C=1, V=0);
  - the FlagW bit meaning.
- One natural sub-module, `cond_check`: purely combinational, inputs Cond and the 4-bit flags, output CondEx.
- The top level holds the two flag registers and the gating.

## Test plan
- Reset with RESET=0, RESET_FLAGS=4'b0000, Cond=0000 (EQ), PCS=1 → Flags=0000, CondEx=0, PCSrc=0.
  - Then Cond=1110, RegW=1 → RegWrite=1.
- CMP result: Cond=1110, FlagW=11, ALUFlags=0110, one edge → Flags=0110.
  - Next cycle Cond=0000, PCS=1 → PCSrc=1.
  - Cond=0001 → PCSrc=0.
- Failed condition blocks update: Flags=0100, Cond=0001, FlagW=11, ALUFlags=1001, edge → Flags stay 0100, RegWrite=0, MemWrite=0.
- Partial write and ADC carry: Flags=0000, FlagW=01, ALUFlags=1111, edge → Flags=0011, C_Flag=1.
  - Next: FlagW=10, ALUFlags=1000 → Flags=1011.
  - Cond=1010 (GE) → CondEx=1.
  - Cond=1100 (GT) → CondEx=1.
- Stall freezes state: Stall=1, Cond=1110, FlagW=11, ALUFlags=1111, RegW=1, MemW=1, 3 edges → Flags unchanged, RegWrite=0, MemWrite=0.
  - Stall=0, then one edge → Flags=1111.
- Async reset mid-run: Flags=1111, drop RESET between edges → Flags=RESET_FLAGS before the next edge.
  - With Cond=1010 and NoWrite=1, RegW=1 → RegWrite=0.

Source files
------------

// File: rtl/cond_logic_pkg.sv
// ----------------------------------------------------------------------------
// cond_logic_pkg
//   Shared definitions for the conditional-execution / flag-register stage:
//   ARM condition-code encodings, NZCV bit positions within the 4-bit flag
//   vector, and the meaning of each FlagW bit.
// ----------------------------------------------------------------------------
package cond_logic_pkg;

    // Instruction condition field, bits [31:28].
    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    // Bit positions inside the {N,Z,C,V} flag vector.
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    // FlagW bits: [1] writes the N,Z field, [0] writes the C,V field.
    localparam int unsigned FLAGW_NZ = 1;
    localparam int unsigned FLAGW_CV = 0;

endpackage

// File: rtl/cond_logic_cond_check.sv
// ----------------------------------------------------------------------------
// cond_check
//   Purely combinational condition evaluator.
//   Ports:
//     Cond   in  [3:0]  instruction condition field
//     Flags  in  [3:0]  stored {N,Z,C,V}
//     CondEx out        condition passed
// ----------------------------------------------------------------------------
module cond_check
    import cond_logic_pkg::*;
(
    input  logic [3:0] Cond,
    input  logic [3:0] Flags,
    output logic       CondEx
);

    logic w_n;
    logic w_z;
    logic w_c;
    logic w_v;
    logic w_ge;

    assign w_n  = Flags[FLAG_N];
    assign w_z  = Flags[FLAG_Z];
    assign w_c  = Flags[FLAG_C];
    assign w_v  = Flags[FLAG_V];
    assign w_ge = ~(w_n ^ w_v);

    always_comb begin
        CondEx = 1'b1;
        case (cond_e'(Cond))
            COND_EQ: CondEx = w_z;
            COND_NE: CondEx = ~w_z;
            COND_CS: CondEx = w_c;
            COND_CC: CondEx = ~w_c;
            COND_MI: CondEx = w_n;
            COND_PL: CondEx = ~w_n;
            COND_VS: CondEx = w_v;
            COND_VC: CondEx = ~w_v;
            COND_HI: CondEx = w_c & ~w_z;
            COND_LS: CondEx = ~w_c | w_z;
            COND_GE: CondEx = w_ge;
            COND_LT: CondEx = ~w_ge;
            COND_GT: CondEx = ~w_z & w_ge;
            COND_LE: CondEx = w_z | ~w_ge;
            COND_AL: CondEx = 1'b1;
            // 1111 is left for the decoder to interpret; here it always passes.
            default: CondEx = 1'b1;
        endcase
    end

endmodule

// File: rtl/cond_logic.sv
// ----------------------------------------------------------------------------
// cond_logic
//   Conditional-execution and NZCV flag-register stage after the ALU.
//   Parameters:
//     RESET_FLAGS       {N,Z,C,V} value loaded while RESET is low
//   Ports:
//     CLK      in        clock, rising edge
//     RESET    in        asynchronous active-low reset
//     Cond     in  [3:0] instruction condition field
//     ALUFlags in  [3:0] {N,Z,C,V} from the ALU, same cycle
//     FlagW    in  [1:0] [1] write N,Z   [0] write C,V
//     PCS      in        decoder PC-write request
//     RegW     in        decoder register-write request
//     MemW     in        decoder memory-write request
//     NoWrite  in        compare-type instruction, no register write
//     Stall    in        freeze all architectural updates
//     PCSrc    out       gated PC write
//     RegWrite out       gated register write
//     MemWrite out       gated memory write
//     CondEx   out       condition passed on the stored flags
//     C_Flag   out       stored C, ALU carry-in for ADC
//     Flags    out [3:0] stored {N,Z,C,V}
// ----------------------------------------------------------------------------
module cond_logic
    import cond_logic_pkg::*;
#(
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       RegW,
    input  logic       MemW,
    input  logic       NoWrite,
    input  logic       Stall,
    output logic       PCSrc,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       CondEx,
    output logic       C_Flag,
    output logic [3:0] Flags
);

    logic [1:0] r_nz;
    logic [1:0] r_cv;
    logic [3:0] w_flags;
    logic       w_cond_ex;
    logic       w_commit;

    assign w_flags = {r_nz, r_cv};

    // Evaluated on stored flags only: an S-suffixed conditional instruction
    // sees the old flags and its new flags land at the edge (no bypass).
    cond_check u_cond_check (
        .Cond   (Cond),
        .Flags  (w_flags),
        .CondEx (w_cond_ex)
    );

    assign w_commit = w_cond_ex & ~Stall;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_nz <= RESET_FLAGS[3:2];
        end else if (w_commit && FlagW[FLAGW_NZ]) begin
            r_nz <= ALUFlags[FLAG_N:FLAG_Z];
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_cv <= RESET_FLAGS[1:0];
        end else if (w_commit && FlagW[FLAGW_CV]) begin
            r_cv <= ALUFlags[FLAG_C:FLAG_V];
        end
    end

    assign CondEx   = w_cond_ex;
    assign PCSrc    = PCS & w_commit;
    assign RegWrite = RegW & ~NoWrite & w_commit;
    assign MemWrite = MemW & w_commit;
    assign C_Flag   = r_cv[FLAG_C];
    assign Flags    = w_flags;

endmodule

// File: tb/tb_cond_logic.sv
// ----------------------------------------------------------------------------
// tb_cond_logic
//   Directed stimulus for cond_logic. Each vector pushes a hand-computed
//   expected output word {Flags, C_Flag, CondEx, PCSrc, RegWrite, MemWrite}
//   into a queue; an independent monitor pops and compares at each falling
//   edge, i.e. with the vector's inputs applied and before the commit edge.
// ----------------------------------------------------------------------------
module tb_cond_logic;

    logic       CLK;
    logic       RESET;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS;
    logic       RegW;
    logic       MemW;
    logic       NoWrite;
    logic       Stall;
    logic       PCSrc;
    logic       RegWrite;
    logic       MemWrite;
    logic       CondEx;
    logic       C_Flag;
    logic [3:0] Flags;

    int unsigned errors = 0;
    int unsigned checks = 0;

    string      q_name[$];
    logic [8:0] q_exp[$];

    cond_logic #(.RESET_FLAGS(4'b0000)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .Cond     (Cond),
        .ALUFlags (ALUFlags),
        .FlagW    (FlagW),
        .PCS      (PCS),
        .RegW     (RegW),
        .MemW     (MemW),
        .NoWrite  (NoWrite),
        .Stall    (Stall),
        .PCSrc    (PCSrc),
        .RegWrite (RegWrite),
        .MemWrite (MemWrite),
        .CondEx   (CondEx),
        .C_Flag   (C_Flag),
        .Flags    (Flags)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Monitor: compare whenever an expectation is pending.
    initial begin
        string      nm;
        logic [8:0] ex;
        logic [8:0] got;
        forever begin
            @(negedge CLK);
            if (q_exp.size() > 0) begin
                nm  = q_name.pop_front();
                ex  = q_exp.pop_front();
                got = {Flags, C_Flag, CondEx, PCSrc, RegWrite, MemWrite};
                checks++;
                if (got !== ex) begin
                    errors++;
                    $display("FAIL %s: got {Flags,C,CondEx,PCSrc,RegWr,MemWr}=%b_%b_%b_%b_%b_%b required %b_%b_%b_%b_%b_%b",
                             nm, got[8:5], got[4], got[3], got[2], got[1], got[0],
                             ex[8:5], ex[4], ex[3], ex[2], ex[1], ex[0]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

    // One vector per cycle: drive after the rising edge, expectation checked
    // at the falling edge, inputs committed at the following rising edge.
    task automatic apply(input string nm, input logic rst, input logic [3:0] c,
                         input logic [3:0] alu, input logic [1:0] fw,
                         input logic pcs, input logic regw, input logic memw,
                         input logic nw, input logic stall,
                         input logic [3:0] e_flags, input logic e_c,
                         input logic e_cex, input logic e_pc,
                         input logic e_rw, input logic e_mw);
        @(posedge CLK);
        #1;
        RESET    = rst;
        Cond     = c;
        ALUFlags = alu;
        FlagW    = fw;
        PCS      = pcs;
        RegW     = regw;
        MemW     = memw;
        NoWrite  = nw;
        Stall    = stall;
        q_name.push_back(nm);
        q_exp.push_back({e_flags, e_c, e_cex, e_pc, e_rw, e_mw});
        @(negedge CLK);
        #1;
    endtask

    initial begin
        RESET = 1'b0; Cond = 4'b0000; ALUFlags = 4'b0000; FlagW = 2'b00;
        PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; NoWrite = 1'b0; Stall = 1'b0;

        //     name             rst cond     alu      fw     pcs  rw   mw   nw   st     flags    C    cex  pc   rw   mw
        apply("reset_eq",       0, 4'b0000, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        apply("reset_al_regw",  0, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        apply("cmp_write",      1, 4'b1110, 4'b0110, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        apply("beq_taken",      1, 4'b0000, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0110, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        apply("bne_not_taken",  1, 4'b0001, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        apply("set_0100",       1, 4'b1110, 4'b0100, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0110, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        apply("fail_blocks",    1, 4'b0001, 4'b1001, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        apply("held_clear",     1, 4'b1110, 4'b0000, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        apply("partial_cv",     1, 4'b1110, 4'b1111, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        apply("partial_nz",     1, 4'b1110, 4'b1000, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0011, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        apply("ge_pass",        1, 4'b1010, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1011, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        apply("gt_pass",        1, 4'b1100, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1011, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        apply("le_fail",        1, 4'b1101, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        apply("ls_fail",        1, 4'b1001, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        apply("hi_pass",        1, 4'b1000, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1011, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        apply("stall_1",        1, 4'b1110, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'b1011, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        apply("stall_2",        1, 4'b1110, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'b1011, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        apply("stall_3",        1, 4'b1110, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'b1011, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        apply("unstall",        1, 4'b1110, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1011, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        apply("eqs_old_flags",  1, 4'b0000, 4'b0000, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        apply("eq_new_flags",   1, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        apply("set_1111",       1, 4'b1110, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        apply("pre_reset",      1, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        // RESET drops between edges; flags must already be cleared at the check.
        apply("async_reset",    0, 4'b1010, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        apply("reset_hold",     0, 4'b1110, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        apply("post_release",   1, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 5 && q_exp.size() > 0; i++) begin
            @(negedge CLK);
            #1;
        end
        if (q_exp.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: got %0d pending expectations required 0", q_exp.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
